// File: rtl/booth_seq_multiplier.sv
// Sequential radix-2 Booth multiplier: 6x6 signed operands, 12-bit signed product.
// One Booth step per clock; a 7-bit accumulator absorbs the -32 subtraction case.
module booth_seq_multiplier (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  multiplicand,
  input  logic [5:0]  multiplier,
  output logic [11:0] product,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  logic [5:0]  m_reg;
  logic [5:0]  q_cap;
  logic [6:0]  a;
  logic [5:0]  qreg;
  logic        q_1;
  logic [2:0]  count;

  logic [6:0]  m_ext;
  logic [6:0]  sum;
  logic [6:0]  a_next;
  logic [5:0]  q_next;
  logic        q1_next;

  // One Booth step: conditional add/subtract followed by arithmetic shift right
  always_comb begin
    m_ext = {m_reg[5], m_reg};
    sum   = a;
    case ({qreg[0], q_1})
      2'b01:   sum = a + m_ext;
      2'b10:   sum = a - m_ext;
      default: sum = a;
    endcase
    a_next  = {sum[6], sum[6:1]};
    q_next  = {sum[0], qreg[5:1]};
    q1_next = qreg[0];
  end

  // Control FSM and datapath registers; busy/done are registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      m_reg   <= '0;
      q_cap   <= '0;
      a       <= '0;
      qreg    <= '0;
      q_1     <= 1'b0;
      count   <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            m_reg <= multiplicand;
            q_cap <= multiplier;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          a     <= '0;
          qreg  <= q_cap;
          q_1   <= 1'b0;
          count <= 3'd6;
          state <= RUN;
        end
        RUN: begin
          a     <= a_next;
          qreg  <= q_next;
          q_1   <= q1_next;
          count <= count - 3'd1;
          // product is taken from the post-step value so it is valid on DONE entry
          if (count == 3'd1) begin
            product <= {a_next[5:0], q_next};
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
